sev_seg_capture: RTL

Recovers hex digits from a time-multiplexed, active-low seven-segment display bus (anodes plus shared cathodes). It is the receiving end of the display path fed by our binary-to-segment decoder and scan driver. It waits for each anode's pattern to be stable, inverse-decodes the pattern into a 4-bit value and flags illegal patterns. Use it for self-check on the board and as the display monitor in benches.

---
 rtl/sev_seg_pkg.sv | 28 ++
 rtl/sev_seg_inverse_lut.sv | 30 +++
 rtl/sev_seg_capture.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sev_seg_pkg
// Brief    : Shared seven-segment pattern table and capture FSM state type.
// Revision : 1.0
// ============================================================================
package sev_seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } cap_state_t;

    // Active-low cathodes ordered [g,f,e,d,c,b,a]
    localparam seg_t SEG_HEX_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/sev_seg_inverse_lut.sv
`default_nettype none
// ============================================================================
// Module   : sev_seg_inverse_lut
// Brief    : Combinational pattern-to-nibble lookup with hit and blank flags.
// Revision : 1.0
// ============================================================================
module sev_seg_inverse_lut
    import sev_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX_LUT[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

    assign blank = (seg == SEG_BLANK);

endmodule
`default_nettype wire

// File: rtl/sev_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : sev_seg_capture
// Brief    : Recovers hex digits from a multiplexed active-low 7-seg bus.
//            Define SEV_SEG_CAP_SYNC_EN to add a two-flop input synchronizer.
// Revision : 1.0
// ============================================================================
module sev_seg_capture
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output logic                    frame_done
);

    localparam int                    c_cnt_w   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0]    c_cnt_one = c_cnt_w'(1);
    localparam logic [NUM_DIGITS-1:0] c_sel_one = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0] r_s_an;
    seg_t                  r_s_seg;
    logic [NUM_DIGITS-1:0] r_prev_an;
    seg_t                  r_prev_seg;

    logic [NUM_DIGITS-1:0] w_sel;
    logic                  w_legal;
    logic                  w_same;
    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_seen_set;
    logic [3:0]            w_nibble;
    logic                  w_hit;
    logic                  w_blank;

    cap_state_t            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [NUM_DIGITS-1:0] r_seen;
    logic                  r_update;
    logic                  r_frame_done;

`ifdef SEV_SEG_CAP_SYNC_EN
    logic [NUM_DIGITS-1:0] r_sync1_an;
    logic [NUM_DIGITS-1:0] r_sync2_an;
    seg_t                  r_sync1_seg;
    seg_t                  r_sync2_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_an  <= '1;
            r_sync2_an  <= '1;
            r_sync1_seg <= '1;
            r_sync2_seg <= '1;
            r_s_an      <= '1;
            r_s_seg     <= '1;
        end else begin
            r_sync1_an  <= an;
            r_sync2_an  <= r_sync1_an;
            r_sync1_seg <= seg;
            r_sync2_seg <= r_sync1_seg;
            r_s_an      <= r_sync2_an;
            r_s_seg     <= r_sync2_seg;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_an  <= '1;
            r_s_seg <= '1;
        end else begin
            r_s_an  <= an;
            r_s_seg <= seg;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_an  <= '1;
            r_prev_seg <= '1;
        end else begin
            r_prev_an  <= r_s_an;
            r_prev_seg <= r_s_seg;
        end
    end

    // Exactly one anode low: non-zero and a power of two
    assign w_sel      = ~r_s_an;
    assign w_legal    = (w_sel != '0) && ((w_sel & (w_sel - c_sel_one)) == '0);
    assign w_same     = (r_s_an == r_prev_an) && (r_s_seg == r_prev_seg);
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
    assign w_capture  = (r_state == SETTLE) && w_legal && w_same && (w_cnt_inc == c_cnt_max);
    assign w_seen_set = r_seen | w_sel;

    sev_seg_inverse_lut u_lut (
        .seg    (r_s_seg),
        .nibble (w_nibble),
        .hit    (w_hit),
        .blank  (w_blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_seen       <= '0;
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_update     <= w_capture;
            r_frame_done <= 1'b0;
            if (w_capture) begin
                if (&w_seen_set) begin
                    r_seen       <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_seen <= w_seen_set;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state <= SETTLE;
                        r_cnt   <= c_cnt_one;
                    end
                end
                SETTLE: begin
                    if (!w_legal) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!w_same) begin
                        r_cnt <= c_cnt_one;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_capture) begin
                            r_state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!w_same) begin
                        if (w_legal) begin
                            r_state <= SETTLE;
                            r_cnt   <= c_cnt_one;
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] r_nib;
        logic       r_valid;
        logic       r_err;

        // Blank and illegal patterns keep the last good nibble
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_nib   <= 4'h0;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_capture && w_sel[gi]) begin
                if (w_hit) begin
                    r_nib   <= w_nibble;
                    r_valid <= 1'b1;
                    r_err   <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                    r_err   <= ~w_blank;
                end
            end
        end

        assign digits[4*gi +: 4] = r_nib;
        assign digit_valid[gi]   = r_valid;
        assign digit_err[gi]     = r_err;
    end

    assign update     = r_update;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
